// File: rtl/timer_pkg.sv
// Shared constants and types for the stopwatch / countdown timer family.
package timer_pkg;

  // Binary widths of the HH:MM:SS fields, shared with digit_extractor.
  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;

  // Default field limits (23:59:59).
  localparam int unsigned HR_MAX_DEF  = 23;
  localparam int unsigned MIN_MAX_DEF = 59;
  localparam int unsigned SEC_MAX_DEF = 59;

  // Countdown controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

endpackage

// File: rtl/hms_decrement.sv
// Combinational one-second decrement of an HH:MM:SS value with borrow chain.
// The caller guarantees the input is nonzero, so the hour never underflows.
module hms_decrement
  import timer_pkg::*;
#(
  parameter int unsigned MIN_MAX = MIN_MAX_DEF,
  parameter int unsigned SEC_MAX = SEC_MAX_DEF
) (
  input  logic [HR_W-1:0]  hr,
  input  logic [MIN_W-1:0] min,
  input  logic [SEC_W-1:0] sec,
  output logic [HR_W-1:0]  hr_dec,
  output logic [MIN_W-1:0] min_dec,
  output logic [SEC_W-1:0] sec_dec,
  output logic             is_zero_next
);

  localparam logic [MIN_W-1:0] MIN_RELOAD = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] SEC_RELOAD = SEC_W'(SEC_MAX);

  // Seconds borrow from minutes, minutes borrow from hours.
  always_comb begin
    hr_dec  = hr;
    min_dec = min;
    sec_dec = sec;
    if (sec != {SEC_W{1'b0}}) begin
      sec_dec = sec - 6'd1;
    end else begin
      sec_dec = SEC_RELOAD;
      if (min != {MIN_W{1'b0}}) begin
        min_dec = min - 6'd1;
      end else begin
        min_dec = MIN_RELOAD;
        hr_dec  = hr - 5'd1;
      end
    end
    is_zero_next = (hr_dec == {HR_W{1'b0}}) && (min_dec == {MIN_W{1'b0}}) &&
                   (sec_dec == {SEC_W{1'b0}});
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer: preset load with clamping, 1 Hz decrement,
// pause/resume and a one-cycle expiry pulse. All outputs are registered.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned HR_MAX  = HR_MAX_DEF,
  parameter int unsigned MIN_MAX = MIN_MAX_DEF,
  parameter int unsigned SEC_MAX = SEC_MAX_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             tick,
  input  logic             load,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  input  logic             start,
  input  logic             pause,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             run,
  output logic             done,
  output logic             expired
);

  localparam logic [HR_W-1:0]  HR_LIM  = HR_W'(HR_MAX);
  localparam logic [MIN_W-1:0] MIN_LIM = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] SEC_LIM = SEC_W'(SEC_MAX);

  cd_state_t        state_q, state_d;
  logic [HR_W-1:0]  hr_q, hr_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;

  logic [HR_W-1:0]  hr_dec_s;
  logic [MIN_W-1:0] min_dec_s;
  logic [SEC_W-1:0] sec_dec_s;
  logic             zero_next_s;
  logic             zero_now_s;

  hms_decrement #(
    .MIN_MAX (MIN_MAX),
    .SEC_MAX (SEC_MAX)
  ) u_dec (
    .hr           (hr_q),
    .min          (min_q),
    .sec          (sec_q),
    .hr_dec       (hr_dec_s),
    .min_dec      (min_dec_s),
    .sec_dec      (sec_dec_s),
    .is_zero_next (zero_next_s)
  );

  assign zero_now_s = (hr_q == {HR_W{1'b0}}) && (min_q == {MIN_W{1'b0}}) &&
                      (sec_q == {SEC_W{1'b0}});

  // Next-state, next-count and flag logic; load outranks every state action.
  always_comb begin
    state_d   = state_q;
    hr_d      = hr_q;
    min_d     = min_q;
    sec_d     = sec_q;
    expired_d = 1'b0;
    if (load) begin
      hr_d    = (set_hr  > HR_LIM)  ? HR_LIM  : set_hr;
      min_d   = (set_min > MIN_LIM) ? MIN_LIM : set_min;
      sec_d   = (set_sec > SEC_LIM) ? SEC_LIM : set_sec;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !zero_now_s) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            hr_d  = hr_dec_s;
            min_d = min_dec_s;
            sec_d = sec_dec_s;
            if (zero_next_s) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (start && !pause) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    run_d  = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, count and flag registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      hr_q      <= {HR_W{1'b0}};
      min_q     <= {MIN_W{1'b0}};
      sec_q     <= {SEC_W{1'b0}};
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      run_q     <= run_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign hr      = hr_q;
  assign min     = min_q;
  assign sec     = sec_q;
  assign run     = run_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule
